// File: rtl/supercar_scanner_if.sv
// supercar_scanner_if
//   Board-level signal bundle for the scanner: pushbuttons in, four
//   seven-segment digits out.
//   KEY[3:0]   : [0] sync reset (1 = reset), [1] speed (0 = fast),
//                [2] run (0 = paused), [3] unused
//   HEX0..HEX3 : {g,f,e,d,c,b,a}, active-low; HEX3 is the leftmost digit
//   master : drives KEY, observes HEX (board / testbench side)
//   slave  : observes KEY, drives HEX (scanner side)
interface supercar_scanner_if;
  logic [3:0] KEY;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;

  modport master (
    output KEY,
    input  HEX0, HEX1, HEX2, HEX3
  );

  modport slave (
    input  KEY,
    output HEX0, HEX1, HEX2, HEX3
  );
endinterface

// File: rtl/supercar_scanner.sv
// supercar_scanner
//   "Knight Rider" scanner: a two-segment bar sweeps HEX3 -> HEX0 and back,
//   bouncing at each end. Eight bar positions (left and right segment pair
//   of each of the four digits), one step per prescaler tick.
//   CLOCK_50 : system clock, all state updates on its rising edge
//   bus      : KEY in (reset / speed / run), HEX0..HEX3 out (active-low)
//   DIV_SLOW : clock cycles per step in normal speed
//   DIV_FAST : clock cycles per step in fast speed
module supercar_scanner #(
  parameter int DIV_SLOW = 12500000,
  parameter int DIV_FAST = 3125000
) (
  input logic                CLOCK_50,
  supercar_scanner_if.slave  bus
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(DIV_FAST - 1);

  localparam logic [6:0] SEG_LEFT  = 7'b1001111;  // segments f,e lit
  localparam logic [6:0] SEG_RIGHT = 7'b1111001;  // segments c,b lit
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic             rst;
  logic             run;
  logic [CNT_W-1:0] limit_m1;
  logic             unused_key3;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             tick;

  assign rst         = bus.KEY[0];
  assign run         = bus.KEY[2];
  assign unused_key3 = bus.KEY[3];

  // KEY[1] low selects the fast rate
  assign limit_m1 = bus.KEY[1] ? SLOW_M1 : FAST_M1;

  // State register: reset wins over pause, speed and tick on the same edge
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      cnt_q <= '0;
      pos_q <= 3'd0;
      dir_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  // Next state: prescaler and bouncing position
  always_comb begin
    cnt_d = cnt_q;
    pos_d = pos_q;
    dir_d = dir_q;
    tick  = 1'b0;

    if (run) begin
      // >= rather than == so a count left above a newly selected, shorter
      // limit still wraps on the next cycle instead of running to overflow
      if (cnt_q >= limit_m1) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (tick) begin
      if (!dir_q) begin
        if (pos_q == 3'd7) begin
          pos_d = 3'd6;
          dir_d = 1'b1;
        end else begin
          pos_d = pos_q + 3'd1;
        end
      end else begin
        if (pos_q == 3'd0) begin
          pos_d = 3'd1;
          dir_d = 1'b0;
        end else begin
          pos_d = pos_q - 3'd1;
        end
      end
    end
  end

  // Output decode: pos[0] picks the segment pair, pos[2:1] picks the digit
  // counting from the left (0 -> HEX3 ... 3 -> HEX0)
  always_comb begin
    logic [6:0] seg;
    seg      = pos_q[0] ? SEG_RIGHT : SEG_LEFT;
    bus.HEX0 = SEG_BLANK;
    bus.HEX1 = SEG_BLANK;
    bus.HEX2 = SEG_BLANK;
    bus.HEX3 = SEG_BLANK;
    case (pos_q[2:1])
      2'd0:    bus.HEX3 = seg;
      2'd1:    bus.HEX2 = seg;
      2'd2:    bus.HEX1 = seg;
      default: bus.HEX0 = seg;
    endcase
  end

endmodule

// File: tb/tb_supercar_scanner.sv
// tb_supercar_scanner
//   Directed bench for supercar_scanner with DIV_SLOW=4, DIV_FAST=2.
//   Expected displays come from a hand-written position table.
module tb_supercar_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  supercar_scanner_if bus();

  supercar_scanner #(
    .DIV_SLOW(4),
    .DIV_FAST(2)
  ) dut (
    .CLOCK_50(clk),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Expected {HEX3,HEX2,HEX1,HEX0} for each bar position
  function automatic logic [27:0] disp(input int p);
    case (p)
      0: disp = {7'b1001111, 7'b1111111, 7'b1111111, 7'b1111111};
      1: disp = {7'b1111001, 7'b1111111, 7'b1111111, 7'b1111111};
      2: disp = {7'b1111111, 7'b1001111, 7'b1111111, 7'b1111111};
      3: disp = {7'b1111111, 7'b1111001, 7'b1111111, 7'b1111111};
      4: disp = {7'b1111111, 7'b1111111, 7'b1001111, 7'b1111111};
      5: disp = {7'b1111111, 7'b1111111, 7'b1111001, 7'b1111111};
      6: disp = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1001111};
      7: disp = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111001};
      default: disp = '1;
    endcase
  endfunction

  task automatic check(input string tag, input int exp_pos);
    logic [27:0] got;
    logic [27:0] exp;
    got = {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
    exp = disp(exp_pos);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (pos %0d)", tag, got, exp, exp_pos);
  endtask

  // Advance n rising edges, then sample 1 time unit later
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int seq [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  initial begin
    int prev;

    // Reset
    bus.KEY = 4'b0001;
    cyc(2);
    check("reset", 0);

    // Normal sweep, bounce at 7, back to 0, then on to 1
    bus.KEY = 4'b1110;
    prev = 0;
    for (int k = 0; k < 15; k++) begin
      cyc(3);
      check($sformatf("hold_step%0d", k + 1), prev);
      cyc(1);
      check($sformatf("step%0d", k + 1), seq[k]);
      prev = seq[k];
    end

    // Fast speed: one step every 2 cycles (pos 1, cnt 0)
    bus.KEY = 4'b1100;
    cyc(1);
    check("fast_hold", 1);
    cyc(1);
    check("fast_step2", 2);
    cyc(2);
    check("fast_step3", 3);

    // Fast -> slow with cnt=1: tick after 3 more cycles
    cyc(1);
    bus.KEY = 4'b1110;
    cyc(2);
    check("to_slow_hold", 3);
    cyc(1);
    check("to_slow_step", 4);

    // Slow -> fast with stale cnt=2 above fast limit: tick on next cycle
    cyc(2);
    bus.KEY = 4'b1100;
    cyc(1);
    check("stale_cnt_tick", 5);
    bus.KEY = 4'b1110;

    // Pause at pos 5 with cnt=2
    cyc(2);
    bus.KEY = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cyc(5);
      check($sformatf("pause%0d", k), 5);
    end

    // Resume: cnt kept, so tick after 2 cycles
    bus.KEY = 4'b1110;
    cyc(1);
    check("resume_hold", 5);
    cyc(1);
    check("resume_step", 6);
    cyc(4);
    check("to7", 7);
    cyc(4);
    check("bounce6", 6);
    cyc(4);
    check("left5", 5);

    // Mid-operation reset at pos 5 moving left, cnt=2
    cyc(2);
    bus.KEY = 4'b1111;
    cyc(1);
    check("mid_reset", 0);
    bus.KEY = 4'b1101;
    cyc(10);
    check("reset_hold", 0);

    // Release with KEY[3]=0: cnt restarted, moving right
    bus.KEY = 4'b0110;
    cyc(3);
    check("post_reset_hold", 0);
    cyc(1);
    check("post_reset_step1", 1);
    cyc(4);
    check("post_reset_step2", 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/supercar_scanner.md
Name: supercar_scanner

Overview:
- "Knight Rider" light scanner for the DE-board four-digit 7-segment display.
- A single lit bar of two vertical segments sweeps HEX3→HEX0 and back, bouncing at each end.
- The step rate comes from a prescaler on CLOCK_50. Pushbuttons provide reset, speed select and pause.
- Top-level board block; no other modules attached.

Parameters:
- DIV_SLOW, 12500000, CLOCK_50 cycles per step in normal speed (4 steps/s at 50 MHz).
- DIV_FAST, 3125000, CLOCK_50 cycles per step in fast speed (16 steps/s).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz; all state updates on its rising edge.
- KEY  input  4  [0] reset, synchronous, active-high; [1] speed select, 0=fast, 1=normal; [2] pause, 0=paused, 1=run; [3] unused.
- HEX0  output  7  rightmost digit, segments {g,f,e,d,c,b,a} = bits [6:0], active-low (0 = lit).
- HEX1  output  7  digit 1, same encoding.
- HEX2  output  7  digit 2, same encoding.
- HEX3  output  7  leftmost digit, same encoding.

Behaviour:
- State registers:
  - pos[2:0], bar position 0..7.
  - dir, 0 = moving right (pos increments), 1 = moving left.
  - cnt, prescaler, wide enough for DIV_SLOW-1 (24 bits at default).
- Reset (KEY[0]=1 at a rising edge):
  - pos=0, dir=0, cnt=0.
  - Reset overrides pause, speed and tick on the same edge.
  - Mid-sweep reset returns to pos 0 on the next edge.
- Prescaler:
  - limit = DIV_FAST when KEY[1]=0, else DIV_SLOW.
  - Run (KEY[2]=1): if cnt >= limit-1, then cnt←0 and tick=1 for that cycle; else cnt←cnt+1.
  - Pause (KEY[2]=0): cnt and pos/dir hold, no tick.
  - Speed change mid-count: the >= compare makes a stale cnt above the new limit tick on the next run cycle. No lockup.
- Position update on tick:
  - dir=0, pos<7: pos←pos+1.
  - dir=0, pos=7: pos←6, dir←1.
  - dir=1, pos>0: pos←pos-1.
  - dir=1, pos=0: pos←1, dir←0.
  - Sequence 0,1,…,7,6,…,1,0,1,…; period 14 ticks. The end positions are each shown for exactly one step.
- Display decode (combinational from pos):
  - Even pos → left pair (f,e) of its digit = 7'b1001111.
  - Odd pos → right pair (c,b) of its digit = 7'b1111001.
  - pos 0,1 → HEX3; pos 2,3 → HEX2; pos 4,5 → HEX1; pos 6,7 → HEX0.
  - All non-selected digits = 7'b1111111 (blank).
  - Exactly one digit is non-blank at any time.
- Output values:
  - After reset: HEX3=1001111, HEX2=HEX1=HEX0=1111111.
  - Latency: HEX outputs change on the same edge that updates pos, i.e. the edge at which tick is 1.
  - One step occurs every limit cycles when running.
- KEY[3] and any X on unused inputs have no effect on behaviour.

Test Plan:
- Reset: DIV_SLOW=4, DIV_FAST=2; KEY=4'b0001 for 2 edges → HEX3=1001111, HEX2..HEX0=1111111, pos=0.
- Normal sweep: release reset with KEY=4'b1110, run 4 cycles per step.
  - HEX3 goes 1001111 → 1111001.
  - HEX2 then shows 1001111 after step 2, and so on to HEX0=1111001 at step 7.
- Bounce: continue from pos 7.
  - Next steps give pos 6 (HEX0=1001111), then 5 (HEX1=1111001).
  - Sweep back to HEX3=1001111 at step 14, then pos 1 at step 15.
- Fast speed: KEY=4'b1100 → position advances every 2 cycles. Switch to KEY=4'b1110 mid-count → next tick within ≤4 cycles, no skipped or stuck position.
- Pause: KEY=4'b1010 for 20 cycles → HEX outputs and pos constant. Return to 4'b1110 → resumes from same pos/dir and same cnt.
- Mid-operation reset: at pos 5 moving left, KEY=4'b1111 for one edge → pos 0, dir right, HEX3=1001111. KEY=4'b1101 holds the display in reset state indefinitely.
